// File: rtl/aes_inv_key_sequencer_if.sv
// Key-stream bundle between the inverse key sequencer and the inverse-round datapath.
// Carries the start/key request and the valid/ready round-key stream.
interface aes_inv_key_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic [127:0]     key;
  logic             busy;
  logic             valid;
  logic             ready;
  logic [127:0]     round_key;
  logic [IDX_W-1:0] round_idx;
  logic             done;

  modport master (
    input  start, key, ready,
    output busy, valid, round_key, round_idx, done
  );

  modport slave (
    output start, key, ready,
    input  busy, valid, round_key, round_idx, done
  );
endinterface

// File: rtl/aes_inv_key_sequencer.sv
// AES-128 inverse-cipher key source: expands once, then streams round keys 10..0.
// Optional AES_KEY_REUSE_EN skips expansion when the same key is requested again.
module aes_inv_key_sequencer #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input logic iClk,
  input logic iRst,
  aes_inv_key_sequencer_if.master bus
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    SERVE,
    DONE
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] expand(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t           state, state_nxt;
  logic [127:0]     keys [0:NR];
  logic [3:0]       cnt;
  logic [7:0]       rcon;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic             done;
  logic [127:0]     round_key;
  logic             hit;
  logic             last_round;
  logic [127:0]     next_key;

  assign last_round = (cnt == 4'(NR - 1));
  assign next_key   = expand(keys[cnt], rcon);

`ifdef AES_KEY_REUSE_EN
  logic [127:0] last_key;
  logic         last_vld;

  assign hit = last_vld && (bus.key == last_key);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      last_key <= '0;
      last_vld <= 1'b0;
    end else if (state == EXPAND && last_round) begin
      last_key <= keys[0];
      last_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = hit ? SERVE : EXPAND;
      EXPAND:  if (last_round) state_nxt = SERVE;
      SERVE:   if (valid && bus.ready && idx == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i <= NR; i++) keys[i] <= '0;
      cnt       <= '0;
      rcon      <= 8'h01;
      idx       <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
      round_key <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            keys[0] <= bus.key;
            cnt     <= '0;
            rcon    <= 8'h01;
            if (hit) idx <= IDX_W'(NR);
          end
        end
        EXPAND: begin
          keys[cnt + 4'd1] <= next_key;
          cnt  <= cnt + 4'd1;
          rcon <= xtime(rcon);
          if (last_round) idx <= IDX_W'(NR);
        end
        SERVE: begin
          // first SERVE cycle only loads the presentation register
          if (!valid) begin
            valid     <= 1'b1;
            round_key <= keys[idx];
          end else if (bus.ready) begin
            if (idx == '0) begin
              valid <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx       <= idx - 1'b1;
              round_key <= keys[idx - 1'b1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.valid     = valid;
  assign bus.round_key = round_key;
  assign bus.round_idx = idx;
  assign bus.done      = done;

endmodule

// File: tb/tb_aes_inv_key_sequencer.sv
// Directed bench for aes_inv_key_sequencer using FIPS-197 key schedules.
// Reuse latency expectations follow AES_KEY_REUSE_EN.
module tb_aes_inv_key_sequencer;

  logic clk;
  logic rst;

  aes_inv_key_sequencer_if #(.IDX_W(4)) kif ();

  aes_inv_key_sequencer #(.NR(10), .IDX_W(4)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (kif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KX = 128'hffeeddccbbaa99887766554433221100;

`ifdef AES_KEY_REUSE_EN
  localparam int LAT_RE = 1;
`else
  localparam int LAT_RE = 11;
`endif

  logic [127:0] exp2 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int tests = 0;
  int fails = 0;
  logic [127:0] got [0:10];
  int lat, n, dones, stall_bad, order_bad;
  bit found;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, 128'(kif.valid), 128'd0);
    chk({tag, "_busy"},  128'(kif.busy),  128'd0);
    chk({tag, "_done"},  128'(kif.done),  128'd0);
    chk({tag, "_key"},   kif.round_key,   128'd0);
    chk({tag, "_idx"},   128'(kif.round_idx), 128'd0);
  endtask

  // caller sits at a negedge; the following posedge is edge 0
  task automatic start_key(input logic [127:0] k);
    kif.start = 1'b1;
    kif.key   = k;
    @(negedge clk);
    kif.start = 1'b0;
  endtask

  task automatic run(input logic [127:0] k, input bit stall,
                     input bit inject);
    bit pv, pr, rdy;
    logic [127:0] pk;
    logic [3:0] pi;
    int exp_idx;
    pv = 0; pr = 0; pk = '0; pi = '0; exp_idx = 10;
    lat = -1; n = 0; dones = 0; stall_bad = 0; order_bad = 0;
    for (int i = 0; i <= 10; i++) got[i] = '0;
    start_key(k);
    for (int c = 0; c < 50; c++) begin
      if (kif.valid && lat < 0) lat = c;
      if (pv && !pr && kif.valid &&
          (kif.round_key !== pk || kif.round_idx !== pi))
        stall_bad++;
      if (kif.done) dones++;
      kif.start = 1'b0;
      if (inject && (c == 3 || c == 14 || kif.done ||
                     (kif.valid && kif.round_idx == 4'd0))) begin
        kif.start = 1'b1;
        kif.key   = KX;
      end
      rdy = !stall || (lat >= 0 && (c - lat) % 3 == 0);
      kif.ready = rdy;
      if (kif.valid && rdy) begin
        if (int'(kif.round_idx) != exp_idx) order_bad++;
        if (kif.round_idx <= 4'd10) got[kif.round_idx] = kif.round_key;
        exp_idx--;
        n++;
      end
      pv = kif.valid; pr = rdy; pk = kif.round_key; pi = kif.round_idx;
      @(negedge clk);
    end
    kif.start = 1'b0;
    kif.ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    kif.start = 1'b0;
    kif.key = '0;
    kif.ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst("por");
    rst = 1'b0;
    @(negedge clk);

    run(K1, 1'b0, 1'b0);
    chk("k1_lat", 128'(lat), 128'd11);
    chk("k1_n", 128'(n), 128'd11);
    chk("k1_done", 128'(dones), 128'd1);
    chk("k1_order", 128'(order_bad), 128'd0);
    chk("k1_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("k1_r5",  got[5],  128'h3caaa3e8a99f9deb50f3af57adf622aa);
    chk("k1_r1",  got[1],  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("k1_r0",  got[0],  K1);

    run(K1, 1'b0, 1'b0);
    chk("k1b_lat", 128'(lat), 128'(LAT_RE));
    chk("k1b_n", 128'(n), 128'd11);
    chk("k1b_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("k1b_r0",  got[0],  K1);

    run(K2, 1'b0, 1'b1);
    chk("k2i_lat", 128'(lat), 128'd11);
    chk("k2i_n", 128'(n), 128'd11);
    chk("k2i_done", 128'(dones), 128'd1);
    chk("k2i_order", 128'(order_bad), 128'd0);
    chk("k2i_idle", 128'(kif.busy), 128'd0);
    for (int i = 0; i <= 10; i++)
      chk($sformatf("k2i_r%0d", i), got[i], exp2[i]);

    run(K2, 1'b1, 1'b0);
    chk("stall_n", 128'(n), 128'd11);
    chk("stall_order", 128'(order_bad), 128'd0);
    chk("stall_hold", 128'(stall_bad), 128'd0);
    chk("stall_done", 128'(dones), 128'd1);
    chk("stall_r10", got[10], exp2[10]);
    chk("stall_r0", got[0], exp2[0]);

    start_key(K1);
    repeat (4) @(negedge clk);
    chk("mid_exp_busy", 128'(kif.busy), 128'd1);
    rst = 1'b1;
    #1;
    chk_rst("rst_exp");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(K2, 1'b0, 1'b0);
    chk("post1_lat", 128'(lat), 128'd11);
    chk("post1_n", 128'(n), 128'd11);
    chk("post1_r10", got[10], exp2[10]);
    chk("post1_r0", got[0], exp2[0]);

    start_key(K2);
    kif.ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (kif.valid && kif.round_idx == 4'd6) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_srv_found", 128'(found), 128'd1);
    chk("mid_srv_key", kif.round_key, exp2[6]);
    rst = 1'b1;
    #1;
    chk_rst("rst_srv");
    kif.ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(K1, 1'b0, 1'b0);
    chk("post2_lat", 128'(lat), 128'd11);
    chk("post2_n", 128'(n), 128'd11);
    chk("post2_done", 128'(dones), 128'd1);
    chk("post2_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("post2_r5",  got[5],  128'h3caaa3e8a99f9deb50f3af57adf622aa);
    chk("post2_r1",  got[1],  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("post2_r0",  got[0],  K1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
